// File: rtl/down_counter_timer_if.sv
// Handshake-free control/status bundle for the down counter timer.
// Master drives load/enable controls; slave returns count and flags.
interface down_counter_timer_if #(
  parameter int Width = 8
);
  logic             en_i;
  logic             load_i;
  logic [Width-1:0] data_i;
  logic             mode_i;
  logic [Width-1:0] cnt_o;
  logic             tc_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output en_i, load_i, data_i, mode_i,
    input  cnt_o, tc_o, busy_o, done_o
  );

  modport slave (
    input  en_i, load_i, data_i, mode_i,
    output cnt_o, tc_o, busy_o, done_o
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable enable-gated down counter with one-shot and
// auto-reload modes and a one-cycle terminal-count pulse.
module down_counter_timer #(
  parameter int Width = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  down_counter_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    // Load beats any terminal event in the same cycle
    if (bus.load_i) begin
      cnt_d    = bus.data_i;
      reload_d = bus.data_i;
      mode_d   = bus.mode_i;
      state_d  = (bus.data_i != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.en_i) begin
            if (cnt_q == Width'(1)) begin
              tc_d = 1'b1;
              if (mode_q) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q - Width'(1);
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.tc_o   = tc_q;
  assign bus.busy_o = (state_q == RUN);
  assign bus.done_o = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench: directed steps queue expected outputs,
// a monitor pops and compares one entry after each clock edge.
module tb_down_counter_timer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  down_counter_timer_if #(.Width(8)) bus();

  down_counter_timer #(.Width(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o} !==
          {e.cnt, e.tc, e.busy, e.done}) begin
        failures++;
        $display("FAIL %s: got cnt=%0d tc=%0b busy=%0b done=%0b, want cnt=%0d tc=%0b busy=%0b done=%0b",
                 e.name, bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o,
                 e.cnt, e.tc, e.busy, e.done);
      end
    end
  end

  task automatic step(input logic en, input logic ld,
                      input logic [7:0] data, input logic mode,
                      input logic [7:0] c, input logic tc,
                      input logic busy, input logic done,
                      input string name);
    exp_t e;
    @(negedge clk_i);
    bus.en_i   = en;
    bus.load_i = ld;
    bus.data_i = data;
    bus.mode_i = mode;
    e.cnt = c; e.tc = tc; e.busy = busy; e.done = done; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name);
    checks++;
    if ({bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o} !== 11'b0) begin
      failures++;
      $display("FAIL %s: got cnt=%0d tc=%0b busy=%0b done=%0b, want all zero",
               name, bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o);
    end
  endtask

  task automatic drain(input string name);
    int n;
    @(negedge clk_i);
    bus.en_i   = 1'b0;
    bus.load_i = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard not drained, %0d left, want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en_i   = 1'b0;
    bus.load_i = 1'b0;
    bus.data_i = '0;
    bus.mode_i = 1'b0;
    #3;
    check_now("reset_initial");
    @(negedge clk_i);
    rst_i = 1'b0;

    // one-shot load 5
    step(1, 1, 5, 0, 5, 0, 1, 0, "os_load5");
    step(1, 0, 0, 0, 4, 0, 1, 0, "os_4");
    step(1, 0, 0, 0, 3, 0, 1, 0, "os_3");
    step(1, 0, 0, 0, 2, 0, 1, 0, "os_2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "os_1");
    step(1, 0, 0, 0, 0, 1, 0, 1, "os_tc");
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 0, 0, 0, 0, 1, "os_hold");

    // periodic load 3 with enable gaps
    step(0, 1, 3, 1, 3, 0, 1, 0, "per_load3");
    step(1, 0, 0, 0, 2, 0, 1, 0, "per_2");
    step(0, 0, 0, 0, 2, 0, 1, 0, "per_gap");
    step(1, 0, 0, 0, 1, 0, 1, 0, "per_1");
    step(1, 0, 0, 0, 3, 1, 1, 0, "per_tc");
    step(1, 0, 0, 0, 2, 0, 1, 0, "per_2b");
    step(0, 0, 0, 0, 2, 0, 1, 0, "per_gap2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "per_1b");

    // max load one-shot with enable gaps
    step(1, 1, 255, 0, 255, 0, 1, 0, "max_load");
    for (int k = 1; k < 255; k++) begin
      if (k % 50 == 0)
        step(0, 0, 0, 0, 8'(256 - k), 0, 1, 0, "max_gap");
      step(1, 0, 0, 0, 8'(255 - k), 0, 1, 0, "max_dec");
    end
    step(1, 0, 0, 0, 0, 1, 0, 1, "max_tc");

    // reload of 1 in periodic mode
    step(1, 1, 1, 1, 1, 0, 1, 0, "one_load");
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 1, 1, 1, 0, "one_tc");
    step(0, 0, 0, 1, 1, 0, 1, 0, "one_gap");
    step(1, 0, 0, 1, 1, 1, 1, 0, "one_tc2");

    // load zero stays idle
    step(1, 1, 0, 1, 0, 0, 0, 0, "zero_load");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, 0, 0, 0, "zero_idle");

    // load collides with terminal event
    step(1, 1, 2, 0, 2, 0, 1, 0, "col_load2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "col_1");
    step(1, 1, 7, 0, 7, 0, 1, 0, "col_load7");
    step(1, 0, 0, 0, 6, 0, 1, 0, "col_6");

    // load during DONE restarts
    step(1, 1, 1, 0, 1, 0, 1, 0, "dn_load1");
    step(1, 0, 0, 0, 0, 1, 0, 1, "dn_tc");
    step(1, 0, 0, 0, 0, 0, 0, 1, "dn_hold");
    step(0, 1, 4, 0, 4, 0, 1, 0, "dn_load4");
    step(1, 0, 0, 0, 3, 0, 1, 0, "dn_3");

    // mode_i without load has no effect
    step(1, 1, 2, 0, 2, 0, 1, 0, "md_load2");
    step(1, 0, 0, 1, 1, 0, 1, 0, "md_1");
    step(1, 0, 0, 1, 0, 1, 0, 1, "md_tc");
    drain("pre_reset");

    // reset mid-count
    step(1, 1, 10, 1, 10, 0, 1, 0, "rs_load10");
    step(1, 0, 0, 0, 9, 0, 1, 0, "rs_9");
    step(1, 0, 0, 0, 8, 0, 1, 0, "rs_8");
    step(1, 0, 0, 0, 7, 0, 1, 0, "rs_7");
    step(1, 0, 0, 0, 6, 0, 1, 0, "rs_6");
    drain("reset_mid");
    #2;
    rst_i = 1'b1;
    #1;
    check_now("reset_async");
    @(negedge clk_i);
    check_now("reset_hold");
    rst_i = 1'b0;
    step(1, 1, 2, 0, 2, 0, 1, 0, "rs_load2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "rs_1");
    step(1, 0, 0, 0, 0, 1, 0, 1, "rs_tc");
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, enable-gated down counter with terminal-count detection. It is the decrementing counterpart of the team's loadable up counter.
- Used as a programmable interval timer: software/FSM loads a count, the block decrements on enabled cycles and flags terminal count.
- Two modes: one-shot (stop at zero) and periodic (auto-reload).

Parameters:
- Width, 8, bit width of count, load data and reload register.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- en_i  input  1  count enable; a decrement occurs only on cycles with en_i=1.
- load_i  input  1  load strobe; captures data_i and mode_i, and starts the timer.
- data_i  input  Width  start/reload value, sampled when load_i=1.
- mode_i  input  1  0 = one-shot, 1 = periodic. Sampled only when load_i=1.
- cnt_o  output  Width  current count (registered).
- tc_o  output  1  terminal-count pulse, one cycle wide (registered).
- busy_o  output  1  high while in RUN.
- done_o  output  1  high while in DONE (one-shot expired).

Behaviour:
- Reset (rst_i=1, asynchronous, takes effect immediately, independent of clk_i):
  - cnt_o=0, tc_o=0, busy_o=0, done_o=0.
  - Internal reload register=0, mode register=0, state=IDLE.
  - Outputs hold these values until the first rising edge after rst_i deasserts.
- State machine: IDLE, RUN, DONE.
  - busy_o = (state==RUN).
  - done_o = (state==DONE).
- Load:
  - Priority: load_i beats en_i, accepted in any state, en_i not required.
  - Actions: cnt_o<=data_i, reload_q<=data_i, mode_q<=mode_i, tc_o<=0.
  - If data_i!=0, next state is RUN.
  - If data_i==0, next state is IDLE; no tc_o is generated.
- IDLE: cnt_o holds; en_i is ignored.
- RUN with en_i=0: cnt_o frozen, tc_o=0, state unchanged.
- RUN with en_i=1 and cnt_o>1: cnt_o<=cnt_o-1, tc_o<=0.
- RUN with en_i=1 and cnt_o==1 (terminal event): tc_o<=1 for exactly one cycle.
  - One-shot (mode_q=0): cnt_o<=0, state becomes DONE.
  - Periodic (mode_q=1): cnt_o<=reload_q, state stays RUN.
  - Period is reload_q enabled cycles. With reload_q=1, tc_o is high on every enabled cycle.
- DONE: cnt_o holds 0, tc_o=0, en_i ignored. Exits only via load_i (or reset).
- Arithmetic: unsigned modulo-2^Width. Decrement from 0 never occurs, because RUN is never entered with count 0.
- Maximum load value: 2^Width-1 gives 2^Width-1 enabled cycles to terminal count.
- Load coincident with a terminal event: load wins, tc_o stays 0, new value is loaded.
- mode_i changes without load_i have no effect.
- Reset mid-count: all state cleared immediately. The terminal event in flight is lost and tc_o goes 0 asynchronously.
- Latency:
  - Load to cnt_o: 1 cycle.
  - In one-shot, tc_o asserts N clock edges after the load edge for data_i=N when en_i is held at 1. It coincides with cnt_o becoming 0.

Test Plan:
- Reset check: assert rst_i between clock edges -> cnt_o=0, tc_o=0, busy_o=0, done_o=0 immediately, without a clock edge.
- One-shot: load 5, mode 0, en_i=1 -> cnt_o 5,4,3,2,1,0 on successive edges; tc_o high only in the cycle cnt_o=0; done_o=1, busy_o=0; cnt_o stays 0 for 10 further cycles.
- Periodic with gaps: load 3, mode 1, en_i toggled 1,0,1,1,1,1 -> cnt_o 3,2,2,1,3(tc_o=1),2; tc_o never high on en_i=0 cycles.
- Boundaries:
  - Load 255 (Width=8), one-shot -> tc_o after exactly 255 enabled cycles.
  - Load 1, periodic -> tc_o high every enabled cycle, cnt_o stays 1.
  - Load 0 -> state IDLE, busy_o=0, no tc_o ever.
- Collisions:
  - Load 7 in the same cycle cnt_o==1 with en_i=1 -> cnt_o=7, tc_o=0, busy_o=1.
  - Load during DONE -> restarts count from the new value.
- Reset mid-count: load 10, run 4 cycles, pulse rst_i -> cnt_o=0 at once; next load 2 behaves as from a fresh reset.
